// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter block.
// Build option: define COUNTER_SATURATE_EN to make the counter saturate instead of wrap.
package counter_pkg;

  localparam int unsigned COUNTER_DEFAULT_WIDTH = 8;

  // All-ones value for a counter of the given width (1..32)
  function automatic logic [31:0] max_count(input int unsigned width);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    return ones >> (32 - width);
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-value logic for the counter.
// Build option: COUNTER_SATURATE_EN selects hold-at-max instead of wrap-to-zero.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             inc,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(max_count(WIDTH));

  logic w_at_max;

  assign w_at_max = (cur == MAX_VAL);

  always_comb begin
    nxt = cur;
    if (inc) begin
`ifdef COUNTER_SATURATE_EN
      // Pinned at the top value; further increments are dropped
      if (!w_at_max) begin
        nxt = cur + WIDTH'(1);
      end
`else
      nxt = w_at_max ? '0 : cur + WIDTH'(1);
`endif
    end
  end

endmodule

// File: rtl/counter.sv
// Parameterised up-counter: async active-high reset, increments while inc is high.
// Build option: COUNTER_SATURATE_EN (handled in counter_next) saturates at the maximum.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_nxt;

  counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .cur(r_count),
    .inc(inc),
    .nxt(w_nxt)
  );

  // Count register; reset clears it without waiting for a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_nxt;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter at WIDTH 1, 8 and 16 driven by shared clk/rst/inc.
module tb_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inc;
  logic [0:0]  c1;
  logic [7:0]  c8;
  logic [15:0] c16;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  counter #(.WIDTH(1))  u_w1  (.clk(clk), .rst(rst), .inc(inc), .count(c1));
  counter #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .inc(inc), .count(c8));
  counter #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .inc(inc), .count(c16));

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    e1;
    int    e8;
    int    e16;
  } exp_t;

  exp_t sb_q[$];
  event item_ev;

  int m1 = 0;
  int m8 = 0;
  int m16 = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Reference: values live in 0..2^w-1; overflow wraps modulo 2^w or sticks at the top
  function automatic int ref_next(input int v, input int w, input bit do_inc);
    int span;
    span = 1 << w;
    if (!do_inc) return v;
    if (SAT && v == span - 1) return v;
    return (v + 1) % span;
  endfunction

  task automatic model_clear();
    m1 = 0; m8 = 0; m16 = 0;
  endtask

  task automatic push(input string nm);
    exp_t e;
    e.name = nm;
    e.e1 = m1;
    e.e8 = m8;
    e.e16 = m16;
    sb_q.push_back(e);
    -> item_ev;
  endtask

  task automatic check(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: count=%0d expected=%0d at t=%0t", nm, act, exp_v, $time);
  endtask

  // Monitor: drains the scoreboard whenever stimulus posts an expectation
  initial begin
    forever begin
      @(item_ev);
      while (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_w1"},  int'(c1),  e.e1);
        check({e.name, "_w8"},  int'(c8),  e.e8);
        check({e.name, "_w16"}, int'(c16), e.e16);
      end
    end
  end

  // One clock edge: drive inc at the falling edge, update model at the rising edge
  task automatic edge_step(input bit inc_v, input string nm);
    @(negedge clk);
    inc = inc_v;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      m1  = ref_next(m1, 1, inc);
      m8  = ref_next(m8, 8, inc);
      m16 = ref_next(m16, 16, inc);
    end
    #1 push(nm);
  endtask

  // Reset held across n edges with inc high; the drop is checked before any edge
  task automatic rst_edges(input int n, input string nm);
    @(negedge clk);
    rst = 1'b1;
    inc = 1'b1;
    #1;
    model_clear();
    push({nm, "_drop"});
    repeat (n) edge_step(1'b1, nm);
    @(negedge clk);
    rst = 1'b0;
    inc = 1'b0;
  endtask

  // Short reset pulse between edges; must be called just after an edge_step
  task automatic async_pulse(input string nm);
    #1 rst = 1'b1;
    #1;
    model_clear();
    push(nm);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    inc = 1'b0;
    #2 push("reset_state");

    rst_edges(3, "rst_init");
    repeat (5) edge_step(1'b0, "hold_after_reset");
    repeat (255) edge_step(1'b1, "full_run");
    repeat (5) edge_step(1'b0, "held_max");
    edge_step(1'b1, "boundary_255");

    edge_step(1'b0, "pre100");
    async_pulse("pre100_rst");
    repeat (100) edge_step(1'b1, "to_100");
    edge_step(1'b0, "at_100");
    async_pulse("mid_op_rst");
    repeat (3) edge_step(1'b1, "after_rst");

    repeat (20) edge_step(1'b1, "pre_rst_mid");
    rst_edges(3, "rst_mid_count");

    repeat (400) begin
      edge_step(1'($urandom_range(0, 1)), "random");
      if ($urandom_range(0, 29) == 0) async_pulse("random_rst");
    end

    edge_step(1'b0, "pre_sweep");
    async_pulse("pre_sweep_rst");
    repeat (65535) edge_step(1'b1, "sweep16");
    edge_step(1'b0, "w16_max_hold");
    edge_step(1'b1, "w16_boundary");

    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
